// File: rtl/piso_serializer_if.sv
// Parallel-in handshake plus serial-out status bundle for piso_serializer.
// The producer drives din/din_valid (master); the serializer drives the rest (slave).
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             word_done;
  logic [7:0]       words_sent;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, busy, word_done, words_sent
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, busy, word_done, words_sent
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter feeding a bit-serial sequence detector.
// Three-state FSM (IDLE/SHIFT/GAP) with optional idle gap after every word.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter bit IDLE_BIT  = 1'b1,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  piso_serializer_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    bit_reg, bit_next;
  logic [3:0]       gap_reg, gap_next;
  logic             done_reg, done_next;
  logic [7:0]       sent_reg;

  logic [WIDTH-1:0] load_word;
  logic             last_bit;
  logic             accept;

  // The shifter always emits its MSB, so LSB-first words are loaded bit-reversed.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_load
      assign load_word[gi] = LSB_FIRST ? bus.din[WIDTH-1-gi] : bus.din[gi];
    end
  endgenerate

  assign last_bit      = (state_reg == ST_SHIFT) && (bit_reg == '0);
  assign bus.din_ready = (state_reg == ST_IDLE) || (last_bit && (GAP == 0));
  assign accept        = bus.din_valid && bus.din_ready;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    gap_next   = gap_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SHIFT;
          shift_next = load_word;
          bit_next   = CW'(WIDTH - 1);
        end
      end
      ST_SHIFT: begin
        if (bit_reg != '0) begin
          shift_next = {shift_reg[WIDTH-2:0], 1'b0};
          bit_next   = bit_reg - 1'b1;
        end else begin
          done_next = 1'b1;
          if (GAP > 0) begin
            state_next = ST_GAP;
            gap_next   = 4'(GAP - 1);
          end else if (accept) begin
            // Zero-gap streaming: reload in place so x_valid never drops.
            shift_next = load_word;
            bit_next   = CW'(WIDTH - 1);
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      bit_reg   <= '0;
      gap_reg   <= '0;
      done_reg  <= 1'b0;
      sent_reg  <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
      gap_reg   <= gap_next;
      done_reg  <= done_next;
      sent_reg  <= sent_reg + 8'(done_next);
    end
  end

  assign bus.x          = (state_reg == ST_SHIFT) ? shift_reg[WIDTH-1] : IDLE_BIT;
  assign bus.x_valid    = (state_reg == ST_SHIFT);
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.word_done  = done_reg;
  assign bus.words_sent = sent_reg;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for three serializer configurations: default, GAP=2, LSB-first.
// Expected bits are queued on each accepted word and popped as x_valid bits appear.
module tb_piso_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam int GAPS [3] = '{0, 2, 0};
  localparam bit LSBS [3] = '{1'b0, 1'b0, 1'b1};

  piso_serializer_if #(.WIDTH(8)) b0 ();
  piso_serializer_if #(.WIDTH(8)) b1 ();
  piso_serializer_if #(.WIDTH(8)) b2 ();

  piso_serializer #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b1), .LSB_FIRST(1'b0))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  piso_serializer #(.WIDTH(8), .GAP(2), .IDLE_BIT(1'b1), .LSB_FIRST(1'b0))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  piso_serializer #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b1), .LSB_FIRST(1'b1))
    u2 (.clk(clk), .rst(rst), .bus(b2));

  logic [7:0] din [3];
  logic       dv  [3];
  logic       xv [3], xo [3], rdy [3], bz [3], wd [3];
  logic [7:0] ws [3];

  assign b0.din = din[0]; assign b0.din_valid = dv[0];
  assign b1.din = din[1]; assign b1.din_valid = dv[1];
  assign b2.din = din[2]; assign b2.din_valid = dv[2];
  assign xv[0] = b0.x_valid; assign xo[0] = b0.x; assign rdy[0] = b0.din_ready;
  assign xv[1] = b1.x_valid; assign xo[1] = b1.x; assign rdy[1] = b1.din_ready;
  assign xv[2] = b2.x_valid; assign xo[2] = b2.x; assign rdy[2] = b2.din_ready;
  assign bz[0] = b0.busy; assign wd[0] = b0.word_done; assign ws[0] = b0.words_sent;
  assign bz[1] = b1.busy; assign wd[1] = b1.word_done; assign ws[1] = b1.words_sent;
  assign bz[2] = b2.busy; assign wd[2] = b2.word_done; assign ws[2] = b2.words_sent;

  typedef struct packed {
    logic b;
    logic last;
  } item_t;

  item_t      q [3][$];
  logic       last_pop [3];
  logic       exp_done [3];
  logic [7:0] exp_sent [3];
  int         gl [3];
  logic       acc_last [3];
  int         gap_seen;
  int         checks = 0;
  int         passed = 0;
  int         failed = 0;

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s[dut%0d]: got %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  // One clock: decide accepts, advance the model at the edge, then check 1ns later.
  task automatic tick();
    logic       acc [3];
    logic [7:0] w [3];
    logic       r;
    item_t      it;
    int         nb;
    r = rst;
    for (int i = 0; i < 3; i++) begin
      acc[i] = !r && dv[i] && (rdy[i] === 1'b1);
      w[i]   = din[i];
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      acc_last[i] = acc[i];
      if (r) begin
        q[i].delete();
        last_pop[i] = 1'b0;
        gl[i]       = 0;
        exp_done[i] = 1'b0;
        exp_sent[i] = 8'd0;
      end else begin
        exp_done[i] = last_pop[i];
        if (last_pop[i]) begin
          exp_sent[i] = exp_sent[i] + 8'd1;
          gl[i]       = GAPS[i];
        end
        if (acc[i]) begin
          for (int b = 0; b < 8; b++) begin
            it.b    = LSBS[i] ? w[i][b] : w[i][7-b];
            it.last = (b == 7);
            q[i].push_back(it);
          end
        end
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      nb = q[i].size();
      chk("x_valid",    i, 32'(xv[i]),  32'(nb > 0));
      chk("busy",       i, 32'(bz[i]),  32'(nb > 0 || gl[i] > 0));
      chk("din_ready",  i, 32'(rdy[i]), 32'((nb == 0 && gl[i] == 0) || (nb == 1 && GAPS[i] == 0)));
      chk("word_done",  i, 32'(wd[i]),  32'(exp_done[i]));
      chk("words_sent", i, 32'(ws[i]),  32'(exp_sent[i]));
      if (i == 1 && xv[i] === 1'b0 && rdy[i] === 1'b0 && xo[i] === 1'b1) gap_seen++;
      if (nb > 0) begin
        it = q[i].pop_front();
        chk("x", i, 32'(xo[i]), 32'(it.b));
        last_pop[i] = it.last;
      end else begin
        chk("x_idle", i, 32'(xo[i]), 32'd1);
        last_pop[i] = 1'b0;
        if (gl[i] > 0) gl[i]--;
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  // Present a word and wait (bounded) for its accepting edge; hold keeps din_valid up.
  task automatic send(int i, logic [7:0] w, bit hold);
    din[i] = w;
    dv[i]  = 1'b1;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (acc_last[i]) break;
    end
    chk("accept", i, 32'(acc_last[i]), 32'd1);
    if (!hold) dv[i] = 1'b0;
    din[i] = 8'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = 8'h00;
      dv[i]  = 1'b0;
      last_pop[i] = 1'b0;
      exp_done[i] = 1'b0;
      exp_sent[i] = 8'd0;
      gl[i] = 0;
      acc_last[i] = 1'b0;
    end
    gap_seen = 0;

    // Reset state.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);

    // Single MSB-first word, then back-to-back pair with no bubble.
    send(0, 8'hB1, 1'b0);
    idle(12);
    send(0, 8'h0F, 1'b1);
    send(0, 8'hF0, 1'b0);
    idle(12);

    // Two queued words with a two-cycle gap between them.
    send(1, 8'h5A, 1'b1);
    gap_seen = 0;
    send(1, 8'hC3, 1'b0);
    chk("gap_cycles", 1, 32'(gap_seen), 32'd2);
    idle(14);

    // Reset after the third bit; din_valid held during reset must not be accepted.
    send(0, 8'hAA, 1'b0);
    idle(2);
    rst    = 1'b1;
    din[0] = 8'h01;
    dv[0]  = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_abort_sent", 0, 32'(ws[0]), 32'd0);
    send(0, 8'h01, 1'b0);
    idle(12);

    // LSB-first word.
    send(2, 8'h01, 1'b0);
    idle(12);

    // 256 streamed words wrap the counter back to zero.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 256; k++) send(0, 8'($urandom), (k < 255));
    idle(12);
    chk("wrap", 0, 32'(ws[0]), 32'd0);

    for (int i = 0; i < 3; i++) chk("drain", i, 32'(q[i].size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
